// File: rtl/mat_a_poly_reader_pkg.sv
// Shared constants, the reader FSM state type and the matrix-A base-offset
// helper used by both the ExpandA sampler (write side) and the poly reader.
// No ports: imported by the interface and the RTL modules.
package mat_a_poly_reader_pkg;

    localparam int K               = 8;        // matrix rows
    localparam int L               = 7;        // matrix columns
    localparam int N               = 256;      // coeffs per polynomial
    localparam int Q               = 8380417;  // modulus; stored coeffs are < Q
    localparam int COEFF_WIDTH     = 24;
    localparam int COEFF_PER_WORD  = 4;
    localparam int WORD_LEN        = COEFF_WIDTH * COEFF_PER_WORD;
    localparam int WORDS_PER_POLY  = N / COEFF_PER_WORD;  // 64
    // Word address width of the matrix-A BRAM; the highest used word is 3583.
    localparam int ADDR_POLY_WIDTH = 14;
    localparam int IDX_WIDTH       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // First BRAM word of polynomial A[k][l]: (k*L + l) * 64.
    function automatic logic [ADDR_POLY_WIDTH-1:0] mat_a_base(input logic [3:0] k,
                                                              input logic [3:0] l);
        logic [ADDR_POLY_WIDTH-1:0] kk;
        logic [ADDR_POLY_WIDTH-1:0] ll;
        kk = ADDR_POLY_WIDTH'(k);
        ll = ADDR_POLY_WIDTH'(l);
        return (kk * ADDR_POLY_WIDTH'(L) + ll) * ADDR_POLY_WIDTH'(WORDS_PER_POLY);
    endfunction

endpackage

// File: rtl/mat_a_poly_reader_if.sv
// Bundle of the poly reader's control, BRAM and coefficient-stream signals.
//   control : start, k, l (in)  / busy, done, err (out)
//   BRAM    : en_matA, addr_matA (out) / dout_matA (in, 1-cycle registered read)
//   stream  : coeff_out, coeff_idx, coeff_valid, coeff_last (out) / coeff_ready (in)
//   debug   : state_dbg (out) current FSM state
// Stream handshake: a coefficient transfers on every cycle where coeff_valid and
// coeff_ready are both high; once valid rises, coeff_out/coeff_idx/coeff_last stay
// stable until that transfer, and coeff_valid never depends on coeff_ready.
// modport master = the reader, modport slave = its environment.
interface mat_a_poly_reader_if;
    import mat_a_poly_reader_pkg::*;

    logic                       start;
    logic [3:0]                 k;
    logic [3:0]                 l;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic                       en_matA;
    logic [ADDR_POLY_WIDTH-1:0] addr_matA;
    logic [WORD_LEN-1:0]        dout_matA;
    logic [COEFF_WIDTH-1:0]     coeff_out;
    logic [IDX_WIDTH-1:0]       coeff_idx;
    logic                       coeff_valid;
    logic                       coeff_ready;
    logic                       coeff_last;
    state_e                     state_dbg;

    modport master (
        input  start, k, l, dout_matA, coeff_ready,
        output busy, done, err, en_matA, addr_matA,
               coeff_out, coeff_idx, coeff_valid, coeff_last, state_dbg
    );

    modport slave (
        output start, k, l, dout_matA, coeff_ready,
        input  busy, done, err, en_matA, addr_matA,
               coeff_out, coeff_idx, coeff_valid, coeff_last, state_dbg
    );

endinterface

// File: rtl/mat_a_poly_reader_word_fifo2.sv
// Two-entry word FIFO between the BRAM read port and the lane unpacker.
// Ports: clk, rst (sync, active-high), push_i/data_i write side,
// pop_i read side, data_o = head word, full_o, empty_o, count_o (0..2).
// Push and pop in the same cycle are allowed and leave the count unchanged.
module word_fifo2 #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/mat_a_poly_reader.sv
// Streams polynomial A[k][l] (256 x 24-bit coeffs) out of the matrix-A BRAM.
// Ports: clk, rst (sync, active-high), bus (mat_a_poly_reader_if.master):
// start/k/l request, busy/done/err status, en_matA/addr_matA/dout_matA BRAM
// read port, coeff_* valid/ready coefficient stream, state_dbg FSM state.
// Each 96-bit word carries 4 coeffs, lane i at bits [24*i +: 24].
module mat_a_poly_reader
    import mat_a_poly_reader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    mat_a_poly_reader_if.master bus
);

    state_e                     state_q, state_d;
    logic [ADDR_POLY_WIDTH-1:0] base_q;
    logic [6:0]                 word_cnt_q;   // reads issued, saturates at 64
    logic                       inflight_q;   // read issued last cycle, data arrives now
    logic [1:0]                 lane_q;
    logic [5:0]                 word_idx_q;
    logic                       done_q;
    logic                       err_q;

    logic [WORD_LEN-1:0]        fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [1:0]                 fifo_count;

    logic idx_ok, start_ok, issue, handshake, last_coeff, pop;

    assign idx_ok     = (bus.k < 4'(K)) && (bus.l < 4'(L));
    assign start_ok   = (state_q == ST_IDLE) && bus.start && idx_ok;
    // Occupancy plus in-flight reads bounds the FIFO at two words, so the
    // registered BRAM can never push into a full FIFO.
    assign issue      = (state_q == ST_FETCH) && !word_cnt_q[6] && !fifo_full &&
                        (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2);
    assign handshake  = !fifo_empty && bus.coeff_ready;
    assign last_coeff = (word_idx_q == 6'd63) && (lane_q == 2'd3);
    assign pop        = handshake && (lane_q == 2'd3);

    word_fifo2 #(.W(WORD_LEN)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .data_i  (bus.dout_matA),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_ok) state_d = ST_FETCH;
            ST_FETCH: if (issue && (word_cnt_q == 7'd63)) state_d = ST_DRAIN;
            ST_DRAIN: if (handshake && last_coeff) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            word_cnt_q <= '0;
            inflight_q <= 1'b0;
            lane_q     <= '0;
            word_idx_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= (state_q == ST_DRAIN) && handshake && last_coeff;
            err_q      <= (state_q == ST_IDLE) && bus.start && !idx_ok;
            inflight_q <= issue;
            if (start_ok) begin
                base_q     <= mat_a_base(bus.k, bus.l);
                word_cnt_q <= '0;
                lane_q     <= '0;
                word_idx_q <= '0;
            end else begin
                if (issue) word_cnt_q <= word_cnt_q + 7'd1;
                if (handshake) begin
                    lane_q <= lane_q + 2'd1;
                    if (lane_q == 2'd3) word_idx_q <= word_idx_q + 6'd1;
                end
            end
        end
    end

    // Outputs; stream fields are zeroed while nothing is valid
    always_comb begin
        bus.busy        = (state_q != ST_IDLE);
        bus.done        = done_q;
        bus.err         = err_q;
        bus.en_matA     = issue;
        bus.addr_matA   = issue ? (base_q + ADDR_POLY_WIDTH'(word_cnt_q)) : '0;
        bus.coeff_valid = !fifo_empty;
        bus.coeff_out   = '0;
        bus.coeff_idx   = '0;
        bus.coeff_last  = 1'b0;
        if (!fifo_empty) begin
            bus.coeff_out  = fifo_head[COEFF_WIDTH*lane_q +: COEFF_WIDTH];
            bus.coeff_idx  = {word_idx_q, lane_q};
            bus.coeff_last = last_coeff;
        end
        bus.state_dbg   = state_q;
    end

endmodule

// File: tb/tb_mat_a_poly_reader.sv
// Bench for mat_a_poly_reader: BRAM model, scoreboard of expected coeffs and
// addresses filled when a stream is started and drained as the DUT produces them.
module tb_mat_a_poly_reader;
  import mat_a_poly_reader_pkg::*;

  localparam int EW = 1 + IDX_WIDTH + COEFF_WIDTH;  // {last, idx, coeff}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mat_a_poly_reader_if bus();

  mat_a_poly_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [EW-1:0]              exp_q[$];
  logic [ADDR_POLY_WIDTH-1:0] addr_q[$];
  logic [23:0] salt;
  int n_checks = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rand_ready = 0;
  bit stall_q = 0;
  logic [EW-1:0] held;
  int issued = 0;
  int consumed = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int last_hs_cyc = 0;
  int last_hs_idx = -1;
  int valid_rise_cyc = 0;
  bit prev_valid = 0;

  function automatic logic [23:0] model_coeff(input int a, input int i, input logic [23:0] s);
    logic [23:0] v;
    v = 24'(a * 4 + i) ^ s;
    v[23] = 1'b0;
    return v;
  endfunction

  function automatic logic [WORD_LEN-1:0] pack_word(input int a, input logic [23:0] s);
    logic [WORD_LEN-1:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) w[24*i +: 24] = model_coeff(a, i, s);
    return w;
  endfunction

  // Registered BRAM: data one cycle after the enable
  always @(posedge clk) begin
    if (bus.en_matA) bus.dout_matA <= pack_word(int'(bus.addr_matA), salt);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    logic [ADDR_POLY_WIDTH-1:0] ea;
    cur = {bus.coeff_last, bus.coeff_idx, bus.coeff_out};
    if (stall_q) begin
      chk("stall_valid", 64'(bus.coeff_valid), 64'd1);
      chk("stall_data", 64'(cur), 64'(held));
    end
    if (bus.coeff_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = bus.coeff_valid;
    if (bus.en_matA) begin
      en_cnt++;
      issued++;
      chk("addr_expected", 64'(addr_q.size() != 0), 64'd1);
      if (addr_q.size() != 0) begin
        ea = addr_q.pop_front();
        chk("addr", 64'(bus.addr_matA), 64'(ea));
      end
      chk("fifo_le2", 64'((issued - consumed) <= 2), 64'd1);
    end
    if (bus.coeff_valid && bus.coeff_ready) begin
      chk("coeff_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("coeff", 64'(cur), 64'(e));
      end
      last_hs_cyc = cyc;
      last_hs_idx = int'(bus.coeff_idx);
      if (bus.coeff_idx[1:0] == 2'd3) consumed++;
    end
    stall_q = bus.coeff_valid && !bus.coeff_ready;
    held = cur;
    if (bus.done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (rand_ready) bus.coeff_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    monitor();
  endtask

  task automatic start_stream(input int k, input int l, input logic [23:0] s, output int c0);
    int base;
    base = k * L * 64 + l * 64;
    salt = s;
    for (int w = 0; w < 64; w++) begin
      addr_q.push_back(ADDR_POLY_WIDTH'(base + w));
      for (int i = 0; i < 4; i++)
        exp_q.push_back({(w == 63 && i == 3), 8'(w * 4 + i), model_coeff(base + w, i, s)});
    end
    bus.k = 4'(k);
    bus.l = 4'(l);
    bus.start = 1'b1;
    c0 = cyc;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_drained"}, 64'(exp_q.size() + addr_q.size()), 64'd0);
  endtask

  task automatic wait_idx(input int idx, input string tag);
    int n;
    n = 0;
    while (last_hs_idx != idx && n < 3000) begin
      step();
      n++;
    end
    chk(tag, 64'(last_hs_idx), 64'(idx));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_err"}, 64'(bus.err), 64'd0);
    chk({tag, "_en"}, 64'(bus.en_matA), 64'd0);
    chk({tag, "_addr"}, 64'(bus.addr_matA), 64'd0);
    chk({tag, "_valid"}, 64'(bus.coeff_valid), 64'd0);
    chk({tag, "_out"}, 64'(bus.coeff_out), 64'd0);
    chk({tag, "_idx"}, 64'(bus.coeff_idx), 64'd0);
    chk({tag, "_last"}, 64'(bus.coeff_last), 64'd0);
    chk({tag, "_state"}, 64'(bus.state_dbg), 64'(ST_IDLE));
  endtask

  initial begin
    int c0;
    int c1;
    int e0;
    int d0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.k = '0;
    bus.l = '0;
    bus.coeff_ready = 1'b0;
    salt = '0;
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();
    chk_all_zero("idle");

    // 1: A[0][0], ready held high, ci = 4w+i
    bus.coeff_ready = 1'b1;
    start_stream(0, 0, 24'h0, c0);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    wait_done(400, "t1_done");
    chk("t1_first_valid_lat", 64'((valid_rise_cyc - c0) <= 3), 64'd1);
    chk("t1_no_bubble", 64'(last_hs_cyc - valid_rise_cyc), 64'd255);
    chk("t1_done_after_last", 64'(last_done_cyc - last_hs_cyc), 64'd1);
    chk("t1_total_le_259", 64'((last_done_cyc - c0) <= 259), 64'd1);
    chk("t1_busy_at_done", 64'(bus.busy), 64'd0);
    step();
    chk("t1_done_pulse", 64'(bus.done), 64'd0);

    // 2: A[7][6], last polynomial of the matrix
    start_stream(7, 6, 24'h15A3C5, c0);
    wait_done(400, "t2_done");

    // 3: random backpressure
    rand_ready = 1'b1;
    start_stream(0, 0, 24'h0, c0);
    wait_done(3000, "t3_done");
    rand_ready = 1'b0;
    bus.coeff_ready = 1'b1;
    step();

    // 4: out-of-range indices
    e0 = en_cnt;
    bus.k = 4'd8;
    bus.l = 4'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t4_err_k", 64'(bus.err), 64'd1);
    chk("t4_busy_k", 64'(bus.busy), 64'd0);
    step();
    chk("t4_err_pulse", 64'(bus.err), 64'd0);
    bus.k = 4'd3;
    bus.l = 4'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t4_err_l", 64'(bus.err), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t4_busy", 64'(bus.busy), 64'd0);
    end
    chk("t4_no_en", 64'(en_cnt - e0), 64'd0);

    // 5a: second start mid-stream is ignored
    start_stream(1, 2, 24'h0A0F0F, c0);
    wait_idx(100, "t5_reach_100");
    bus.k = 4'd4;
    bus.l = 4'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(400, "t5_done");

    // 5b: reset at idx 130 aborts, then a fresh stream
    start_stream(3, 3, 24'h333333, c0);
    wait_idx(130, "t5_reach_130");
    rst = 1'b1;
    stall_q = 1'b0;
    step();
    chk_all_zero("t5_rst");
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    issued = 0;
    consumed = 0;
    d0 = done_cnt;
    repeat (10) step();
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    start_stream(3, 3, 24'h333333, c0);
    wait_done(400, "t5_restart_done");

    // 6: back-to-back, second start in the done cycle
    start_stream(2, 5, 24'h00C0DE, c0);
    wait_done(400, "t6_first_done");
    start_stream(6, 0, 24'h7EDCBA, c1);
    chk("t6_accepted", 64'(bus.busy), 64'd1);
    wait_done(400, "t6_second_done");
    chk("t6_total_le_259", 64'((last_done_cyc - c1) <= 259), 64'd1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
